// File: rtl/fma16_unit.sv
// fma16_unit: registered binary16 fused multiply-add with one rounding.
// Build option FMA16_FLAGS_EN: when undefined, flags are tied to zero.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    async active-low reset (result/flags -> 0)
//   x, y, z    binary16 multiplicand, multiplier, addend
//   mul, add   use y / use z (else 1.0 / +0)
//   negp, negz negate product / addend
//   roundmode  00 RZ, 01 RNE, 10 RDN, 11 RUP
//   result     registered binary16 result
//   flags      registered {invalid, overflow, underflow, inexact}
module fma16_unit #(
  parameter logic [15:0] NAN_CANON = 16'h7E00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  input  logic [1:0]  roundmode,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  // Fixed-point accumulator, LSB weight 2^-48.
  // Smallest product LSB is 2^-48, largest
  // sum stays below 2^81, so the add is exact.
  localparam int W = 82;

  localparam logic [1:0] RZ  = 2'b00;
  localparam logic [1:0] RNE = 2'b01;
  localparam logic [1:0] RDN = 2'b10;
  localparam logic [1:0] RUP = 2'b11;

  localparam logic [W-1:0] ONE =
    {{(W-1){1'b0}}, 1'b1};

  function automatic logic f_nan(
    input logic [15:0] v
  );
    return (&v[14:10]) & (|v[9:0]);
  endfunction

  function automatic logic f_snan(
    input logic [15:0] v
  );
    return f_nan(v) & ~v[9];
  endfunction

  function automatic logic f_inf(
    input logic [15:0] v
  );
    return (&v[14:10]) & ~(|v[9:0]);
  endfunction

  function automatic logic f_zero(
    input logic [15:0] v
  );
    return ~(|v[14:0]);
  endfunction

  function automatic logic [10:0] f_sig(
    input logic [15:0] v
  );
    return {|v[14:10], v[9:0]};
  endfunction

  // Subnormals share the exponent of 2^-14.
  function automatic logic [4:0] f_exp(
    input logic [15:0] v
  );
    return (v[14:10] == 5'd0) ? 5'd1
                              : v[14:10];
  endfunction

  logic [15:0] yv;
  logic [15:0] zv;

  assign yv = mul ? y : 16'h3C00;
  assign zv = add ? z : 16'h0000;

  logic sp;
  logic sz;

  assign sp = x[15] ^ yv[15] ^ negp;
  assign sz = zv[15] ^ negz;

  // Operand classification
  logic xnan, ynan, znan;
  logic xinf, yinf, zinf;
  logic xzero, yzero;
  logic anysnan, anynan;
  logic pinf, inval;

  assign xnan  = f_nan(x);
  assign ynan  = f_nan(yv);
  assign znan  = f_nan(zv);
  assign xinf  = f_inf(x);
  assign yinf  = f_inf(yv);
  assign zinf  = f_inf(zv);
  assign xzero = f_zero(x);
  assign yzero = f_zero(yv);

  assign anysnan = f_snan(x) | f_snan(yv)
                 | f_snan(zv);
  assign anynan  = xnan | ynan | znan;
  assign pinf    = (xinf | yinf)
                 & ~xnan & ~ynan;

  assign inval = anysnan
               | (xinf & yzero)
               | (xzero & yinf)
               | (pinf & zinf & (sp != sz));

  // Exact product and alignment
  logic [10:0] mx, my, mz;
  logic [4:0]  ex, ey, ez;
  logic [21:0] mp;
  logic [5:0]  shp, shz;
  logic [W-1:0] ap, az;

  assign mx = f_sig(x);
  assign my = f_sig(yv);
  assign mz = f_sig(zv);
  assign ex = f_exp(x);
  assign ey = f_exp(yv);
  assign ez = f_exp(zv);

  assign mp = {11'd0, mx} * {11'd0, my};

  assign shp = {1'b0, ex} + {1'b0, ey}
             - 6'd2;
  assign shz = {1'b0, ez} + 6'd23;

  assign ap = {{(W-22){1'b0}}, mp} << shp;
  assign az = {{(W-11){1'b0}}, mz} << shz;

  // Sign-magnitude sum
  logic [W-1:0] mag;
  logic         ms;

  always_comb begin
    mag = '0;
    ms  = sp;
    if (sp == sz) begin
      mag = ap + az;
      ms  = sp;
    end else if (ap >= az) begin
      mag = ap - az;
      ms  = sp;
    end else begin
      mag = az - ap;
      ms  = sz;
    end
  end

  // Exact zero: equal-signed zeros keep the
  // sign, true cancellation follows roundmode.
  logic rs;

  always_comb begin
    rs = ms;
    if (mag == '0) begin
      if (sp == sz) rs = sp;
      else          rs = (roundmode == RDN);
    end
  end

  // Normalize
  logic [6:0] lead;

  always_comb begin
    lead = '0;
    for (int i = 0; i < W; i++)
      if (mag[i]) lead = 7'(i);
  end

  // Bit 34 is 2^-14: below it the kept LSB is
  // pinned at 2^-24 (subnormal range).
  logic       norm;
  logic [6:0] k;
  logic [6:0] ebase;

  assign norm  = (lead >= 7'd34);
  assign k     = norm ? lead - 7'd10 : 7'd24;
  assign ebase = norm ? lead - 7'd34 : 7'd0;

  logic [10:0]  q;
  logic         g;
  logic         st;
  logic [W-1:0] smask;

  assign q     = 11'(mag >> k);
  assign g     = mag[k - 7'd1];
  assign smask = (ONE << (k - 7'd1)) - ONE;
  assign st    = |(mag & smask);

  // Round
  logic inc;

  always_comb begin
    inc = 1'b0;
    unique case (roundmode)
      RZ:  inc = 1'b0;
      RNE: inc = g & (st | q[0]);
      RDN: inc = rs & (g | st);
      RUP: inc = ~rs & (g | st);
    endcase
  end

  // Exponent and significand added as one
  // word so a rounding carry bumps exponent.
  logic [11:0] qr;
  logic [16:0] enc;
  logic        ovf;

  assign qr  = {1'b0, q} + {11'd0, inc};
  assign enc = {ebase, 10'b0}
             + {5'b0, qr};
  assign ovf = (enc >= 17'h07C00);

  logic [15:0] ovf_val;

  always_comb begin
    ovf_val = {rs, 15'h7C00};
    unique case (roundmode)
      RZ:  ovf_val = {rs, 15'h7BFF};
      RNE: ovf_val = {rs, 15'h7C00};
      RDN: ovf_val = rs ? 16'hFC00
                        : 16'h7BFF;
      RUP: ovf_val = rs ? 16'hFBFF
                        : 16'h7C00;
    endcase
  end

  logic [15:0] res_d;

  always_comb begin
    res_d = {rs, enc[14:0]};
    if (inval | anynan)
      res_d = NAN_CANON;
    else if (pinf)
      res_d = {sp, 15'h7C00};
    else if (zinf)
      res_d = {sz, 15'h7C00};
    else if (ovf)
      res_d = ovf_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) result <= '0;
    else          result <= res_d;
  end

`ifdef FMA16_FLAGS_EN
  logic [3:0] flg_d;
  logic [3:0] flg_q;
  logic       inx;
  logic       tiny;

  assign inx  = g | st | ovf;
  assign tiny = (enc < 17'h00400);

  always_comb begin
    flg_d = {1'b0, ovf, tiny & inx, inx};
    if (inval)
      flg_d = 4'b1000;
    else if (anynan | pinf | zinf)
      flg_d = 4'b0000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flg_q <= '0;
    else          flg_q <= flg_d;
  end

  assign flags = flg_q;
`else
  assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_fma16_unit.sv
// tb_fma16_unit: directed checks of fma16_unit.
// Expected values are hand-computed binary16.
module tb_fma16_unit;

`ifdef FMA16_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  localparam logic [1:0] RZ  = 2'b00;
  localparam logic [1:0] RNE = 2'b01;
  localparam logic [1:0] RDN = 2'b10;
  localparam logic [1:0] RUP = 2'b11;

  logic        clk;
  logic        reset_n;
  logic [15:0] x, y, z;
  logic        mul, add, negp, negz;
  logic [1:0]  roundmode;
  logic [15:0] result;
  logic [3:0]  flags;

  int n_chk;
  int n_fail;

  fma16_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .x         (x),
    .y         (y),
    .z         (z),
    .mul       (mul),
    .add       (add),
    .negp      (negp),
    .negz      (negz),
    .roundmode (roundmode),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [15:0] er,
    input logic [3:0]  ef
  );
    logic [3:0] efm;
    efm = FLAGS_ON ? ef : 4'b0000;
    n_chk++;
    assert (result === er) else begin
      n_fail++;
      $error("FAIL %s result got %h exp %h",
             tag, result, er);
    end
    n_chk++;
    assert (flags === efm) else begin
      n_fail++;
      $error("FAIL %s flags got %b exp %b",
             tag, flags, efm);
    end
  endtask

  task automatic op(
    input string       tag,
    input logic [15:0] ix,
    input logic [15:0] iy,
    input logic [15:0] iz,
    input logic        im,
    input logic        ia,
    input logic        inp,
    input logic        inz,
    input logic [1:0]  irm,
    input logic [15:0] er,
    input logic [3:0]  ef
  );
    x         = ix;
    y         = iy;
    z         = iz;
    mul       = im;
    add       = ia;
    negp      = inp;
    negz      = inz;
    roundmode = irm;
    @(posedge clk);
    #1;
    check(tag, er, ef);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    x         = 16'h3C00;
    y         = 16'h3C00;
    z         = 16'h0000;
    mul       = 1'b1;
    add       = 1'b0;
    negp      = 1'b0;
    negz      = 1'b0;
    roundmode = RNE;

    repeat (3) @(posedge clk);
    #1;
    check("reset", 16'h0000, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("release", 16'h3C00, 4'b0000);

    // x, y, z, mul, add, negp, negz, rm
    op("fma_rne", 16'h3E00, 16'h4000,
       16'h3C00, 1, 1, 0, 0, RNE,
       16'h4400, 4'b0000);
    op("fma_negp", 16'h3E00, 16'h4000,
       16'h3C00, 1, 1, 1, 0, RNE,
       16'hC000, 4'b0000);

    op("rnd_rne", 16'h3C01, 16'h3C01,
       16'h0000, 1, 0, 0, 0, RNE,
       16'h3C02, 4'b0001);
    op("rnd_rz", 16'h3C01, 16'h3C01,
       16'h0000, 1, 0, 0, 0, RZ,
       16'h3C02, 4'b0001);
    op("rnd_rup", 16'h3C01, 16'h3C01,
       16'h0000, 1, 0, 0, 0, RUP,
       16'h3C03, 4'b0001);
    op("rnd_rdn", 16'h3C01, 16'h3C01,
       16'h0000, 1, 0, 0, 0, RDN,
       16'h3C02, 4'b0001);

    op("ovf_rne", 16'h7BFF, 16'h4000,
       16'h0000, 1, 0, 0, 0, RNE,
       16'h7C00, 4'b0101);
    op("ovf_rz", 16'h7BFF, 16'h4000,
       16'h0000, 1, 0, 0, 0, RZ,
       16'h7BFF, 4'b0101);
    op("ovf_rdn_pos", 16'h7BFF, 16'h4000,
       16'h0000, 1, 0, 0, 0, RDN,
       16'h7BFF, 4'b0101);
    op("ovf_rup_pos", 16'h7BFF, 16'h4000,
       16'h0000, 1, 0, 0, 0, RUP,
       16'h7C00, 4'b0101);
    op("ovf_rdn_neg", 16'h7BFF, 16'h4000,
       16'h0000, 1, 0, 1, 0, RDN,
       16'hFC00, 4'b0101);
    op("ovf_rup_neg", 16'h7BFF, 16'h4000,
       16'h0000, 1, 0, 1, 0, RUP,
       16'hFBFF, 4'b0101);

    op("inv_inf0", 16'h7C00, 16'h0000,
       16'h0000, 1, 0, 0, 0, RNE,
       16'h7E00, 4'b1000);
    op("inv_infinf", 16'h7C00, 16'h3C00,
       16'h7C00, 1, 1, 0, 1, RNE,
       16'h7E00, 4'b1000);
    op("inv_snan", 16'h7C01, 16'h3C00,
       16'h0000, 1, 0, 0, 0, RNE,
       16'h7E00, 4'b1000);
    op("qnan", 16'h3C00, 16'h3C00,
       16'h7E55, 1, 1, 0, 0, RNE,
       16'h7E00, 4'b0000);
    op("inf_ok", 16'h7C00, 16'h4000,
       16'h3C00, 1, 1, 1, 0, RNE,
       16'hFC00, 4'b0000);
    op("inf_z", 16'h3C00, 16'h3C00,
       16'h7C00, 1, 1, 0, 1, RNE,
       16'hFC00, 4'b0000);

    op("cancel_rne", 16'h3C00, 16'h3C00,
       16'h3C00, 1, 1, 0, 1, RNE,
       16'h0000, 4'b0000);
    op("cancel_rdn", 16'h3C00, 16'h3C00,
       16'h3C00, 1, 1, 0, 1, RDN,
       16'h8000, 4'b0000);
    op("negzero", 16'h8000, 16'h3C00,
       16'h8000, 1, 1, 0, 0, RNE,
       16'h8000, 4'b0000);

    op("sub_tie", 16'h0001, 16'h3800,
       16'h0000, 1, 0, 0, 0, RNE,
       16'h0000, 4'b0011);
    op("sub_exact", 16'h0001, 16'h4000,
       16'h0000, 1, 0, 0, 0, RNE,
       16'h0002, 4'b0000);
    op("sub_to_norm", 16'h03FF, 16'h3C01,
       16'h0000, 1, 0, 0, 0, RNE,
       16'h0400, 4'b0001);
    op("sub_rz", 16'h03FF, 16'h3C01,
       16'h0000, 1, 0, 0, 0, RZ,
       16'h03FF, 4'b0011);

    op("mul_off", 16'h4000, 16'h0000,
       16'h0000, 0, 0, 0, 0, RNE,
       16'h4000, 4'b0000);
    op("add_off", 16'h3C00, 16'h3C00,
       16'h7C00, 1, 0, 0, 0, RNE,
       16'h3C00, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fma16_unit.md
Name: fma16_unit

Overview:
- Registered IEEE 754 binary16 fused multiply-add: computes ±(x·y) ± z with a single rounding.
- Sits in the FP execute stage. Operands and control are applied combinationally.
- Result and exception flags are captured on the next rising clock edge.

Parameters:
- NAN_CANON, 16'h7E00, canonical quiet NaN returned for every NaN-producing operation.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- x  input  16  multiplicand, binary16
- y  input  16  multiplier, binary16
- z  input  16  addend, binary16
- mul  input  1  1: use y; 0: treat y as 1.0 (16'h3C00)
- add  input  1  1: use z; 0: treat z as +0
- negp  input  1  negate the product
- negz  input  1  negate the addend
- roundmode  input  2  00 RZ, 01 RNE, 10 RDN (toward -inf), 11 RUP (toward +inf)
- result  output  16  registered binary16 result
- flags  output  4  registered {invalid, overflow, underflow, inexact}

Behaviour:
- Reset: reset_n low asynchronously forces result=16'h0000 and flags=4'b0000, held while low. Outputs first update on the first rising edge after release.
- Latency: exactly 1 cycle. No handshake; a new operation is accepted every cycle. Inputs present at edge N appear on the outputs after edge N.
- Arithmetic: R = round((-1)^negp·x·y' + (-1)^negz·z').
  - y' = mul ? y : 3C00.
  - z' = add ? z : 0000.
- Exactness before rounding:
  - Full 22-bit product significand.
  - Addend aligned with sticky collection, wide enough that cancellation is exact.
  - Normalize, then round once per roundmode.
- Subnormal inputs and outputs fully supported; no flush-to-zero.
- Overflow:
  - RNE → ±inf.
  - RZ → ±7BFF magnitude.
  - RDN → +7BFF / -inf.
  - RUP → +inf / -FBFF.
  - Sets overflow and inexact.
- Underflow: set when the result is tiny (nonzero, |rounded| below 2^-14, detected after rounding) and inexact. Inexact is set whenever the rounded result differs from the exact value.
- Invalid sets invalid, returns NAN_CANON, clears the other flags. Cases:
  - inf·0.
  - Signaling-NaN input.
  - inf - inf, where the product is inf and z' is an opposite-signed inf.
- Quiet-NaN input (no invalid case) returns NAN_CANON with flags=0.
- Infinite operands with a valid result give the correctly signed inf, flags=0.
- Exact zero sum of opposite-signed terms: +0, except RDN gives -0. Same-signed zeros keep their sign.
- Control bits are only meaningful as combined above; all 64 combinations of {roundmode,mul,add,negp,negz} are legal.

Optional Feature:
- Macro: FMA16_FLAGS_EN.
- Defined: flags computed and registered as above.
- Undefined: flags port still present but tied to 4'b0000, and flag logic is omitted. Result values are identical in both builds.

Test Plan:
- Reset: hold reset_n=0 while driving x=3C00,y=3C00,mul=1 and toggling clk → result=0000, flags=0. Release → next edge result=3C00, flags=0.
- Multiply-add RNE: x=3E00,y=4000,z=3C00,mul=1,add=1 → 4400 (1.5·2+1=4), flags=0. Same with negp=1 → C000.
- Rounding modes: x=3C01,y=3C01,mul=1,add=0 (exact value 1+2^-9+2^-20), all with inexact set:
  - RNE → 3C02.
  - RZ → 3C02.
  - RUP → 3C03.
  - RDN → 3C02.
- Overflow: x=7BFF,y=4000,mul=1:
  - RNE → 7C00, flags=0101.
  - RZ → 7BFF, flags=0101.
- Invalid: x=7C00,y=0000,mul=1 → 7E00, flags=1000. Also x=3C00,y=3C00,z=7C00,add=1,negz=1 with product forced to inf via x=7C00 → 7E00, flags=1000.
- Cancellation and subnormal cases:
  - x=3C00,y=3C00,z=3C00,add=1,negz=1: RNE → 0000; RDN → 8000.
  - x=0001,y=3800,mul=1, RNE: exact 2^-25 ties to even → 0000, flags=0011.
